// File: rtl/rf_add_sequencer_pkg.sv
// Shared types for the register-file add sequencer: FSM state encoding,
// write-port requester IDs and default datapath widths.
package rf_add_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  // Encoding is visible on state_dbg, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_SEQ  = 1'b1
  } req_id_t;

endpackage

// File: rtl/rf_add_sequencer_if.sv
// Command/completion bundle of the add sequencer.
//   cmd_*  : add command offer (valid/ready) with rs, rt, rd, carry in
//   done_* : completion pulse plus held result and carry out
// master = command issuer, slave = sequencer.
interface rf_add_sequencer_if
  import rf_add_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_rs;
  logic [ADDR_W-1:0] cmd_rt;
  logic [ADDR_W-1:0] cmd_rd;
  logic              cmd_cin;
  logic              done_valid;
  logic [DATA_W-1:0] done_result;
  logic              done_cout;

  modport master (
    output cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_cin,
    input  cmd_ready, done_valid, done_result, done_cout
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_cin,
    output cmd_ready, done_valid, done_result, done_cout
  );
endinterface

// File: rtl/rf_add_sequencer_wport_arbiter.sv
// 2-way arbiter for the single register-file write port.
//   host_* : host writer request/address/data, host_gnt = write this cycle
//   seq_*  : sequencer writeback request/address/data, seq_gnt
//   wen/waddr/wdata : regfile write port (zero when nobody is granted)
// HOST_PRIO=1: host always wins; 0: round-robin on last_grant.
module rf_wport_arbiter
  import rf_add_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned HOST_PRIO = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              seq_req,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic [DATA_W-1:0] seq_data,
  output logic              host_gnt,
  output logic              seq_gnt,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  req_id_t last_grant_q, last_grant_d;

  always_comb begin
    host_gnt     = 1'b0;
    seq_gnt      = 1'b0;
    wen          = 1'b0;
    waddr        = '0;
    wdata        = '0;
    last_grant_d = last_grant_q;

    if (host_req && seq_req) begin
      if (HOST_PRIO != 0 || last_grant_q == REQ_SEQ) host_gnt = 1'b1;
      else                                           seq_gnt  = 1'b1;
    end else begin
      host_gnt = host_req;
      seq_gnt  = seq_req;
    end

    if (host_gnt) begin
      wen          = 1'b1;
      waddr        = host_addr;
      wdata        = host_data;
      last_grant_d = REQ_HOST;
    end else if (seq_gnt) begin
      wen          = 1'b1;
      waddr        = seq_addr;
      wdata        = seq_data;
      last_grant_d = REQ_SEQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) last_grant_q <= REQ_HOST;
    else         last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/rf_add_sequencer.sv
// Sequences rd <= rs + rt + cin over the 2R/1W regfile and external adder,
// sharing the regfile write port with the host writer.
//   cmd_if        : command offer and completion (rf_add_sequencer_if.slave)
//   rf_raddr*/rf_rdata* : regfile read ports (combinational read)
//   adder_*       : external 32-bit adder operands/result
//   host_w*       : host write request, held until host_wgnt
//   rf_w*         : arbitrated regfile write port
//   busy/state_dbg: status for the display top level
module rf_add_sequencer
  import rf_add_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned HOST_PRIO = 0
) (
  input  logic              clk,
  input  logic              resetn,
  rf_add_sequencer_if.slave cmd_if,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] adder_operand1,
  output logic [DATA_W-1:0] adder_operand2,
  output logic              adder_cin,
  input  logic [DATA_W-1:0] adder_result,
  input  logic              adder_cout,
  input  logic              host_wreq,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_wgnt,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              seq_req, seq_gnt;

  always_comb begin
    state_d           = state_q;
    rs_d              = rs_q;
    rt_d              = rt_q;
    rd_d              = rd_q;
    cin_d             = cin_q;
    op1_d             = op1_q;
    op2_d             = op2_q;
    sum_d             = sum_q;
    cout_d            = cout_q;
    seq_req           = 1'b0;
    cmd_if.cmd_ready  = 1'b0;
    cmd_if.done_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_if.cmd_ready = 1'b1;
        if (cmd_if.cmd_valid) begin
          rs_d    = cmd_if.cmd_rs;
          rt_d    = cmd_if.cmd_rt;
          rd_d    = cmd_if.cmd_rd;
          cin_d   = cmd_if.cmd_cin;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op1_d   = rf_rdata1;
        op2_d   = rf_rdata2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        sum_d   = adder_result;
        cout_d  = adder_cout;
        state_d = S_WB;
      end
      S_WB: begin
        seq_req = 1'b1;
        if (seq_gnt) state_d = S_DONE;
      end
      S_DONE: begin
        cmd_if.done_valid = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      cin_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      cin_q   <= cin_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Read addresses and adder operands come straight from the latched
  // registers in every state, so they stay stable outside READ/EXEC.
  assign rf_raddr1          = rs_q;
  assign rf_raddr2          = rt_q;
  assign adder_operand1     = op1_q;
  assign adder_operand2     = op2_q;
  assign adder_cin          = cin_q;
  assign cmd_if.done_result = sum_q;
  assign cmd_if.done_cout   = cout_q;
  assign busy               = (state_q != S_IDLE);
  assign state_dbg          = state_q;

  rf_wport_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .HOST_PRIO (HOST_PRIO)
  ) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .host_req  (host_wreq),
    .host_addr (host_waddr),
    .host_data (host_wdata),
    .seq_req   (seq_req),
    .seq_addr  (rd_q),
    .seq_data  (sum_q),
    .host_gnt  (host_wgnt),
    .seq_gnt   (seq_gnt),
    .wen       (rf_wen),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata)
  );

endmodule

// File: tb/tb_rf_add_sequencer.sv
module tb_rf_add_sequencer;
  import rf_add_sequencer_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-instance stimulus: instance 0 is HOST_PRIO=0, instance 1 is HOST_PRIO=1.
  logic          s_cmd_valid [2];
  logic [AW-1:0] s_rs [2];
  logic [AW-1:0] s_rt [2];
  logic [AW-1:0] s_rd [2];
  logic          s_cin [2];
  logic          s_hreq [2];
  logic [AW-1:0] s_haddr [2];
  logic [DW-1:0] s_hdata [2];

  logic          o_ready [2];
  logic          o_done [2];
  logic          o_cout [2];
  logic          o_wen [2];
  logic          o_hgnt [2];
  logic          o_busy [2];
  logic [DW-1:0] o_result [2];
  logic [DW-1:0] o_wdata [2];
  logic [AW-1:0] o_waddr [2];
  logic [2:0]    o_state [2];

  logic          r_acc [2];
  logic          r_gnt [2];

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL inst%0d %s: got %0h want %0h at %0t", inst, name, act, exp_v, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    rf_add_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();

    logic [AW-1:0] raddr1, raddr2, waddr;
    logic [DW-1:0] rdata1, rdata2, aop1, aop2, asum, wdata;
    logic          acin, acout, wen, hgnt, busy;
    logic [2:0]    sdbg;
    logic [DW-1:0] rf [32] = '{default: '0};

    assign cif.cmd_valid = s_cmd_valid[g];
    assign cif.cmd_rs    = s_rs[g];
    assign cif.cmd_rt    = s_rt[g];
    assign cif.cmd_rd    = s_rd[g];
    assign cif.cmd_cin   = s_cin[g];

    rf_add_sequencer #(.ADDR_W(AW), .DATA_W(DW), .HOST_PRIO(g)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .cmd_if         (cif),
      .rf_raddr1      (raddr1),
      .rf_raddr2      (raddr2),
      .rf_rdata1      (rdata1),
      .rf_rdata2      (rdata2),
      .adder_operand1 (aop1),
      .adder_operand2 (aop2),
      .adder_cin      (acin),
      .adder_result   (asum),
      .adder_cout     (acout),
      .host_wreq      (s_hreq[g]),
      .host_waddr     (s_haddr[g]),
      .host_wdata     (s_hdata[g]),
      .host_wgnt      (hgnt),
      .rf_wen         (wen),
      .rf_waddr       (waddr),
      .rf_wdata       (wdata),
      .busy           (busy),
      .state_dbg      (sdbg)
    );

    // Environment: combinational-read regfile and 32-bit adder.
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    assign {acout, asum} = 33'(aop1) + 33'(aop2) + 33'(acin);
    always @(posedge clk) if (wen) rf[waddr] <= wdata;

    assign o_ready[g]  = cif.cmd_ready;
    assign o_done[g]   = cif.done_valid;
    assign o_result[g] = cif.done_result;
    assign o_cout[g]   = cif.done_cout;
    assign o_wen[g]    = wen;
    assign o_waddr[g]  = waddr;
    assign o_wdata[g]  = wdata;
    assign o_hgnt[g]   = hgnt;
    assign o_busy[g]   = busy;
    assign o_state[g]  = sdbg;

    // Reference model: one operation in flight, age counts cycles since accept.
    bit            m_valid = 1'b0;
    bit            m_busy;
    int unsigned   m_age;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    logic          m_cin;
    logic [DW-1:0] m_op1, m_op2, m_res;
    logic          m_cout;
    bit            m_last_seq;
    logic [DW-1:0] mref [32] = '{default: '0};

    always @(negedge clk) begin : model
      bit            sreq, hg, sg;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic [DW:0]   full;
      hg = 1'b0;
      sg = 1'b0;
      if (m_valid) begin
        sreq = m_busy && (m_age == 3);
        if (s_hreq[g] && sreq) hg = (g == 1) || m_last_seq;
        else                   hg = s_hreq[g];
        sg = sreq && !hg;
        ea = hg ? s_haddr[g] : (sg ? m_rd : '0);
        ew = hg ? s_hdata[g] : (sg ? m_res : '0);
        check("cmd_ready", g, cif.cmd_ready, !m_busy);
        check("busy", g, busy, m_busy);
        check("state_dbg", g, sdbg, m_busy ? 3'(m_age) : 3'd0);
        check("done_valid", g, cif.done_valid, m_busy && (m_age == 4));
        check("done_result", g, cif.done_result, m_res);
        check("done_cout", g, cif.done_cout, m_cout);
        check("rf_raddr1", g, raddr1, m_rs);
        check("rf_raddr2", g, raddr2, m_rt);
        check("adder_op1", g, aop1, m_op1);
        check("adder_op2", g, aop2, m_op2);
        check("adder_cin", g, acin, m_cin);
        check("rf_wen", g, wen, hg || sg);
        check("rf_waddr", g, waddr, ea);
        check("rf_wdata", g, wdata, ew);
        check("host_wgnt", g, hgnt, hg);

        if (resetn) begin
          if (m_busy) begin
            if (m_age == 1) begin
              m_op1 = mref[m_rs];
              m_op2 = mref[m_rt];
              m_age = 2;
            end else if (m_age == 2) begin
              full   = {1'b0, m_op1} + {1'b0, m_op2} + (DW+1)'(m_cin);
              m_res  = full[DW-1:0];
              m_cout = full[DW];
              m_age  = 3;
            end else if (m_age == 3) begin
              if (sg) m_age = 4;
            end else begin
              m_busy = 1'b0;
              m_age  = 0;
            end
          end else if (s_cmd_valid[g]) begin
            m_rs   = s_rs[g];
            m_rt   = s_rt[g];
            m_rd   = s_rd[g];
            m_cin  = s_cin[g];
            m_busy = 1'b1;
            m_age  = 1;
          end
        end
        if (hg) begin mref[s_haddr[g]] = s_hdata[g]; m_last_seq = 1'b0; end
        if (sg) begin mref[m_rd] = m_res; m_last_seq = 1'b1; end
      end
      if (!resetn) begin
        m_valid = 1'b1; m_busy = 1'b0; m_age = 0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_cin = 1'b0;
        m_op1 = '0; m_op2 = '0; m_res = '0; m_cout = 1'b0;
        m_last_seq = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [AW-1:0] rs, rt, rd, input logic cin);
    for (int i = 0; i < 2; i++) begin
      s_cmd_valid[i] = v; s_rs[i] = rs; s_rt[i] = rt; s_rd[i] = rd; s_cin[i] = cin;
    end
  endtask

  task automatic set_host(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) begin
      s_hreq[i] = r; s_haddr[i] = a; s_hdata[i] = d;
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_host(1'b1, a, d);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("idle_host_wgnt", i, o_hgnt[i], 1'b1);
      check("idle_host_waddr", i, o_waddr[i], a);
      check("idle_cmd_ready", i, o_ready[i], 1'b1);
    end
    tick();
  endtask

  task automatic directed_add(input logic [AW-1:0] rs, rt, rd, input logic cin,
                              input logic [DW-1:0] es, input logic ec);
    set_cmd(1'b1, rs, rt, rd, cin);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("accept_ready", i, o_ready[i], 1'b1);
    tick();
    set_cmd(1'b0, rs, rt, rd, cin);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("add_wen", i, o_wen[i], c == 3);
        check("add_done", i, o_done[i], c == 4);
        if (c == 3) begin
          check("add_waddr", i, o_waddr[i], rd);
          check("add_wdata", i, o_wdata[i], es);
        end
        if (c == 4) begin
          check("add_result", i, o_result[i], es);
          check("add_cout", i, o_cout[i], ec);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_cmd_valid[i] = 1'b0; s_rs[i] = '0; s_rt[i] = '0; s_rd[i] = '0; s_cin[i] = 1'b0;
      s_hreq[i] = 1'b0; s_haddr[i] = '0; s_hdata[i] = '0;
    end
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_done_valid", i, o_done[i], 1'b0);
      check("rst_done_result", i, o_result[i], 32'h0);
      check("rst_busy", i, o_busy[i], 1'b0);
      check("rst_state", i, o_state[i], 3'd0);
      check("rst_ready", i, o_ready[i], 1'b1);
    end
    tick();

    // Three back-to-back host writes with the FSM idle.
    host_write(5'd1, 32'h0000_0005);
    host_write(5'd2, 32'h0000_000A);
    host_write(5'd7, 32'h0000_1234);
    set_host(1'b0, '0, '0);

    directed_add(5'd1, 5'd2, 5'd3, 1'b0, 32'h0000_000F, 1'b0);

    host_write(5'd1, 32'hFFFF_FFFF);
    host_write(5'd2, 32'h0000_0001);
    set_host(1'b0, '0, '0);
    directed_add(5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_0001, 1'b1);

    // Write-port contention right after reset (last grant = host).
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    set_cmd(1'b1, 5'd1, 5'd2, 5'd5, 1'b0);
    @(negedge clk);
    tick();
    set_cmd(1'b0, 5'd1, 5'd2, 5'd5, 1'b0);
    tick(); tick();
    set_host(1'b1, 5'd7, 32'h0000_DEAD);
    @(negedge clk);
    check("wb_seq_first_addr", 0, o_waddr[0], 5'd5);
    check("wb_seq_first_hgnt", 0, o_hgnt[0], 1'b0);
    check("wb_host_first_hgnt", 1, o_hgnt[1], 1'b1);
    check("wb_host_first_data", 1, o_wdata[1], 32'h0000_DEAD);
    tick();
    s_hreq[1] = 1'b0;
    @(negedge clk);
    check("wb_host_next_hgnt", 0, o_hgnt[0], 1'b1);
    check("wb_host_next_addr", 0, o_waddr[0], 5'd7);
    check("wb_done_lat4", 0, o_done[0], 1'b1);
    check("wb_seq_next_addr", 1, o_waddr[1], 5'd5);
    check("wb_seq_next_data", 1, o_wdata[1], 32'h0000_0000);
    check("wb_done_not_yet", 1, o_done[1], 1'b0);
    tick();
    s_hreq[0] = 1'b0;
    @(negedge clk);
    check("wb_done_lat5", 1, o_done[1], 1'b1);
    check("wb_cout", 1, o_cout[1], 1'b1);
    check("wb_idle_ready", 0, o_ready[0], 1'b1);
    tick();

    // cmd_valid held high: second accept exactly 5 cycles after the first.
    set_cmd(1'b1, 5'd1, 5'd7, 5'd8, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("b2b_ready", i, o_ready[i], (c == 0) || (c == 5));
      tick();
    end
    set_cmd(1'b0, 5'd1, 5'd7, 5'd8, 1'b0);
    repeat (5) tick();

    // Reset asserted during EXEC aborts with no write.
    set_cmd(1'b1, 5'd1, 5'd7, 5'd9, 1'b0);
    @(negedge clk);
    tick();
    set_cmd(1'b0, 5'd1, 5'd7, 5'd9, 1'b0);
    @(negedge clk);
    tick();
    resetn = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("exec_state", i, o_state[i], 3'd2);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("abort_wen", i, o_wen[i], 1'b0);
      check("abort_state", i, o_state[i], 3'd0);
      check("abort_result", i, o_result[i], 32'h0);
      check("abort_busy", i, o_busy[i], 1'b0);
    end
    tick();

    // Randomized traffic; the per-instance models check every cycle.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        r_acc[i] = s_cmd_valid[i] && o_ready[i] && resetn;
        r_gnt[i] = o_hgnt[i];
      end
      tick();
      resetn = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        if (r_acc[i] || !s_cmd_valid[i]) begin
          s_cmd_valid[i] = ($urandom_range(0, 2) != 0);
          s_rs[i]  = AW'($urandom_range(0, 7));
          s_rt[i]  = AW'($urandom_range(0, 7));
          s_rd[i]  = AW'($urandom_range(0, 7));
          s_cin[i] = 1'($urandom());
        end
        if (r_gnt[i] || !s_hreq[i]) begin
          s_hreq[i]  = ($urandom_range(0, 2) == 0);
          s_haddr[i] = AW'($urandom_range(0, 7));
          s_hdata[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : DW'($urandom());
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
